mc_control: RTL

- Multicycle MIPS main controller: Moore FSM that sequences fetch/decode/execute/memory/writeback.
- Produces every datapath strobe, including the 4-bit ALU operation code consumed by the ALU.
- Sits between the instruction register (opcode/funct in) and the datapath muxes, register file, memory and ALU.

---
 rtl/mc_control.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// mc_control -- multicycle MIPS main controller.
//
// Moore FSM that walks each instruction through fetch, decode, execute,
// memory and writeback, and drives every datapath strobe, including the
// 4-bit ALU operation code.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset (state -> FETCH)
//   opcode     instr[31:26] from the instruction register
//   funct      instr[5:0] from the instruction register
//   zero       ALU zero flag
//   pc_en      PC load enable (unconditional write or branch-taken)
//   iord       memory address select: 0 = PC, 1 = ALUOut
//   mem_write  memory write strobe
//   ir_write   instruction register load
//   reg_dst    destination register: 0 = rt, 1 = rd
//   mem_to_reg writeback data: 0 = ALUOut, 1 = MDR
//   reg_write  register file write enable
//   alu_src_a  ALU A: 0 = PC, 1 = A register
//   alu_src_b  ALU B: 00 = B, 01 = 4, 10 = ext imm, 11 = sign-ext imm << 2
//   ext_sel    immediate extension: 0 = sign, 1 = zero
//   pc_src     next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_op     ALU operation code
//   illegal    one-cycle pulse on an unsupported opcode/funct
//   state_dbg  current state
module mc_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1101;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_funct_ok;
  logic [3:0] w_funct_alu_op;

  // State register. Outputs decode from this register, so reset presents
  // FETCH strobes at once and kills any in-flight write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_state_next;
    end
  end

  // R-type function decode.
  always_comb begin
    w_funct_ok     = 1'b1;
    w_funct_alu_op = ALU_AND;
    case (funct)
      6'b100000: w_funct_alu_op = ALU_ADD;
      6'b100010: w_funct_alu_op = ALU_SUB;
      6'b100100: w_funct_alu_op = ALU_AND;
      6'b100101: w_funct_alu_op = ALU_OR;
      6'b101010: w_funct_alu_op = ALU_SLT;
      6'b100111: w_funct_alu_op = ALU_NOR;
      6'b000000: w_funct_alu_op = ALU_SLL;
      default:   w_funct_ok     = 1'b0;
    endcase
  end

  // Output and next-state decode.
  always_comb begin
    w_state_next    = S_FETCH;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    iord            = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    reg_write       = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    ext_sel         = 1'b0;
    pc_src          = 2'b00;
    alu_op          = ALU_AND;
    illegal         = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write     = 1'b1;
        alu_src_b    = 2'b01;
        alu_op       = ALU_ADD;
        w_pc_write   = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:             w_state_next = S_MEMADR;
          OP_RTYPE:                 w_state_next = S_REXEC;
          OP_BEQ:                   w_state_next = S_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI: w_state_next = S_IEXEC;
          OP_J:                     w_state_next = S_JUMP;
          default: begin
            illegal      = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = ALU_ADD;
        w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord         = 1'b1;
        w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        if (w_funct_ok) begin
          alu_op       = w_funct_alu_op;
          w_state_next = S_RWB;
        end else begin
          illegal = 1'b1;
        end
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a       = 1'b1;
        alu_op          = ALU_SUB;
        pc_src          = 2'b01;
        w_pc_write_cond = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = S_IWB;
        case (opcode)
          OP_ANDI: begin
            alu_op  = ALU_AND;
            ext_sel = 1'b1;
          end
          OP_ORI: begin
            alu_op  = ALU_OR;
            ext_sel = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
      end
      default: begin
        // Unused encodings: everything idle, recover to FETCH.
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Branch enable follows zero combinationally within the BEQ cycle.
  assign pc_en     = w_pc_write | (w_pc_write_cond & zero);
  assign state_dbg = r_state;

endmodule
